// File: rtl/front_end_pkg.sv
// Shared definitions for the multi-channel front-end controller: default
// parameter values and the FSM state encoding.
package front_end_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int CNT_W_DEF = 16;
  localparam int LAT_DEF   = 3;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] S_RUN   = 2'd1;
  localparam logic [STATE_W-1:0] S_DRAIN = 2'd2;
  localparam logic [STATE_W-1:0] S_DONE  = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = S_IDLE,
    ST_RUN   = S_RUN,
    ST_DRAIN = S_DRAIN,
    ST_DONE  = S_DONE
  } state_e;

endpackage

// File: rtl/fe_valid_pipe.sv
// LAT-deep valid-token shift register that tracks reads travelling through
// the datapath. Stage 0 takes the fire pulse; the last stage is the output
// write strobe; the OR of the earlier stages keeps the pipeline advancing
// and tells the FSM whether tokens are still in flight.
module fe_valid_pipe #(
  parameter int LAT = 3
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic flush_i,
  input  logic load_i,
  output logic last_o,
  output logic early_o
);

  logic [LAT-1:0] valid_q;
  logic [LAT-1:0] valid_d;

  // Next line contents: shift in the new token, or empty the line on flush.
  always_comb begin
    valid_d = (valid_q << 1) | LAT'(load_i);
    if (flush_i) begin
      valid_d = '0;
    end
  end

  // Token line register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      valid_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours, as real flops do.
      valid_q <= valid_d;
    end
  end

  assign last_o = valid_q[LAT-1];

  generate
    if (LAT > 1) begin : g_early
      assign early_o = |valid_q[LAT-2:0];
    end else begin : g_no_early
      assign early_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/front_end_mc.sv
// Multi-channel front-end controller. Issues synchronised reads across the
// enabled input FIFOs, advances the datapath, aligns the output write with
// the datapath latency, and reports completion once len words are written.
module front_end_mc
  import front_end_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int LAT   = LAT_DEF
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic             clear,
  input  logic [CNT_W-1:0] len,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic [N_CH-1:0]  empty,
  input  logic             full,
  output logic [N_CH-1:0]  rden,
  output logic             en,
  output logic             wr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_cnt
);

  state_e state_q, state_d;

  logic [CNT_W-1:0] len_q, len_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic fire;
  logic last_issue;
  logic tok_last;
  logic tok_early;

  // Masked-off channels never stall; output space is guaranteed by the
  // almost-full margin, so only new issues look at full.
  assign fire       = (state_q == ST_RUN) && !full && ((empty & mask_q) == '0);
  assign last_issue = (issue_cnt_q == (len_q - CNT_W'(1)));

  fe_valid_pipe #(
    .LAT (LAT)
  ) u_valid_pipe (
    .aclk    (aclk),
    .aresetn (aresetn),
    .flush_i (clear),
    .load_i  (fire),
    .last_o  (tok_last),
    .early_o (tok_early)
  );

  // Next-state, latch and counter update logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    len_d       = len_q;
    mask_d      = mask_q;
    issue_cnt_d = fire     ? issue_cnt_q + CNT_W'(1) : issue_cnt_q;
    word_cnt_d  = tok_last ? word_cnt_q  + CNT_W'(1) : word_cnt_q;

    if (clear && (state_q != ST_IDLE)) begin
      // Abort: return to IDLE with counters frozen at their current values.
      state_d     = ST_IDLE;
      issue_cnt_d = issue_cnt_q;
      word_cnt_d  = word_cnt_q;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !clear) begin
            len_d       = len;
            mask_d      = ch_mask;
            issue_cnt_d = '0;
            word_cnt_d  = '0;
            state_d     = ((len == '0) || (ch_mask == '0)) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (fire && last_issue) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The final write happens in the same cycle the early stages empty.
          if (!tok_early) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (!start) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, job latches and counters.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      mask_q      <= '0;
      issue_cnt_q <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      mask_q      <= mask_d;
      issue_cnt_q <= issue_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign rden     = fire ? mask_q : '0;
  assign en       = fire | tok_early;
  assign wr       = tok_last;
  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  assign word_cnt = word_cnt_q;

endmodule

// File: doc/front_end_mc.md
# front_end_mc

Multi-channel, length-counted successor to the coprocessor front-end controller. It sits between N_CH input FIFOs and one output FIFO of an accelerator datapath. It issues synchronised reads across all enabled channels and advances the datapath pipeline. It aligns the output write with a fixed datapath latency and signals completion once a programmed word count has been fully written. An internal counter replaces the external `last` strobe, and a synchronous abort is added.

## Interface
- N_CH, 4, number of input channels (≥1)
- CNT_W, 16, width of length and word counters
- LAT, 3, datapath latency in cycles from read to write (≥1)

- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- start  in  1  job request, level-sampled in IDLE
- clear  in  1  synchronous abort, highest priority after reset
- len  in  CNT_W  words per channel, latched on start
- ch_mask  in  N_CH  enabled channels, latched on start
- empty  in  N_CH  per-channel input FIFO empty
- full  in  1  output FIFO almost-full; must assert while free space ≤ LAT
- rden  out  N_CH  per-channel read strobe
- en  out  1  datapath pipeline advance
- wr  out  1  output FIFO write strobe
- busy  out  1  high in RUN and DRAIN
- done  out  1  job complete
- word_cnt  out  CNT_W  words written in the current or last job

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset state is IDLE. All outputs and registers reset to 0.
- fire = (state==RUN) && !full && all channels with mask_q=1 have empty=0. Masked-off channels' empty is ignored.
- rden = mask_q when fire, else 0. en = fire OR any token in stages 0..LAT-2 of the valid line.
- Valid line: LAT-bit shift register. Stage 0 loads fire. wr = last stage.
- issue_cnt increments on fire. word_cnt increments on wr. Both wrap modulo 2^CNT_W, unreachable since issue stops at len.
- IDLE: on start, latch len→len_q and ch_mask→mask_q, and zero issue_cnt and word_cnt.
  - If len==0 or ch_mask==0, go to DONE.
  - Otherwise go to RUN.
- RUN: when fire and issue_cnt==len_q-1, go to DRAIN.
- DRAIN: no new fires. When stages 0..LAT-2 hold no token, go to DONE. Any final wr occurs in that same cycle.
- DONE: done=1. Stay while start=1. Go to IDLE when start=0. There is no re-trigger without a start low phase.
- clear=1 in any state: next state IDLE, the valid line is flushed, and counters hold their value. clear has no effect in IDLE. clear wins over start in the same cycle.
- In RUN, full or any enabled empty stalls issue only. In-flight tokens keep draining and wr is never gated by full; the almost-full margin guarantees space.
- aresetn low at any time returns to IDLE immediately and zeroes all outputs, including mid-job. There is no partial-job recovery.

## Timing
- start seen in IDLE at edge t: first rden possible in cycle t+1.
- rden at cycle k produces wr at cycle k+LAT.
- done rises the cycle after the final wr and stays high until start is low.
- len==0 or mask==0: done in cycle t+1, with no rden, en or wr ever asserted.
- busy is registered-state decoded and is high for exactly the RUN and DRAIN cycles.
- Outputs are combinational from state, the valid line, full and empty. There is no input-to-output path through the counters.

## Structure
- Package front_end_pkg holds:
  - state encoding localparams (IDLE=0, RUN=1, DRAIN=2, DONE=3)
  - STATE_W=2
  - the default parameter values
- Sub-module fe_valid_pipe: LAT-deep valid shift register with a synchronous flush input. It exposes stage-LAT-1 (wr) and an OR of the earlier stages (en and drain test).
- The top level holds the FSM, the len/mask latches and both counters.

## Test plan
- N_CH=4, LAT=3, len=5, mask=1111, empty=0, full=0, start at edge 0 → rden=1111 in cycles 1–5, wr in cycles 4–8, done from cycle 9, word_cnt=5.
- len=0, start → done in cycle 1, rden/en/wr never asserted, word_cnt=0.
- mask=0011, len=4, empty[1]=1 in cycles 2–3, empty[3]=1 always → rden=0011 in cycles 1, 4, 5, 6 and never on bits 2–3; 4 wr total.
- len=8, full=1 in cycles 3–6 → no rden in 3–6, in-flight wr still occur, 8 wr total, done the cycle after the 8th wr.
- clear in cycle 3 of a len=10 job → IDLE next cycle, rden/en/wr=0 from then on, done never asserts; a new start runs normally.
- aresetn low in the middle of a RUN → all outputs 0 asynchronously; the block restarts cleanly from IDLE. Holding start high through DONE keeps done=1 with no new job.
